seven_seg_scanner_n: RTL and testbench

Parametrised multiplexed 7-segment display driver. It is the successor to the fixed 4-digit clock_div + scanner + decoder chain.
- Built-in refresh prescaler, N-digit scan, hex decode, per-digit enable, decimal points, PWM brightness, tear-free frame latching.
- Sits between the math/result logic and the board an/seg/dp pins. One instance replaces the divider, scanner and decoder.

---
 rtl/seven_seg_scanner_n_if.sv | 25 ++
 rtl/seven_seg_scanner_n.sv | 143 ++++++++++++++
 tb/tb_seven_seg_scanner_n.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_n_if.sv
// Bus bundle between result logic and the multiplexed 7-segment scanner.
// The slave modport faces the scanner; the master modport faces its user.
interface seven_seg_scanner_n_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   digit_en;
    logic [BRIGHT_W-1:0] brightness;
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                dp;
    logic                frame_tick;

    modport master (
        output data, dp_in, digit_en, brightness,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  data, dp_in, digit_en, brightness,
        output an, seg, dp, frame_tick
    );
endinterface

// File: rtl/seven_seg_scanner_n.sv
// N-digit multiplexed 7-segment driver: prescaler, scan, decode, PWM, frame latch.
// Optional leading-zero blanking at frame latch: define SEVSEG_LZ_BLANK_EN.
module seven_seg_scanner_n #(
    parameter int DIGITS    = 4,
    parameter int DIVIDE_BY = 17,
    parameter int BRIGHT_W  = 4
) (
    input logic clock,
    input logic Reset,
    seven_seg_scanner_n_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIVIDE_BY-1:0] presc_q;
    logic [IW-1:0]        idx_q;
    logic [IW-1:0]        idx_d;
    logic [4*DIGITS-1:0]  sh_data_q;
    logic [DIGITS-1:0]    sh_dp_q;
    logic [DIGITS-1:0]    sh_en_q;
    logic [DIGITS-1:0]    en_d;
    logic                 first_q;
    logic [DIGITS-1:0]    an_q;
    logic [DIGITS-1:0]    an_d;
    logic [6:0]           seg_q;
    logic [6:0]           seg_d;
    logic                 dp_q;
    logic                 dp_d;
    logic                 tick_q;

    logic       slot_end;
    logic       last;
    logic       wrap;
    logic       on;
    logic       lit;
    logic [3:0] nib;
    logic       sel_dp;
    logic       sel_en;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        unique case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        slot_end = &presc_q;
        last     = (idx_q == IW'(DIGITS - 1));
        wrap     = slot_end && last;
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = last ? '0 : idx_q + IW'(1);
        end
    end

    always_comb begin
        on     = presc_q[DIVIDE_BY-1 -: BRIGHT_W] < bus.brightness;
        nib    = '0;
        sel_dp = 1'b0;
        sel_en = 1'b0;
        an_d   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib     = sh_data_q[4*i +: 4];
                sel_dp  = sh_dp_q[i];
                sel_en  = sh_en_q[i];
                an_d[i] = ~(on && sh_en_q[i]);
            end
        end
        lit   = on && sel_en;
        seg_d = lit ? hex7(nib) : 7'h7F;
        dp_d  = lit ? ~sel_dp : 1'b1;
    end

`ifdef SEVSEG_LZ_BLANK_EN
    logic supp;

    // Walk down from the top digit; a non-zero nibble or a lit dp ends blanking.
    always_comb begin
        en_d = bus.digit_en;
        supp = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (supp && bus.data[4*i +: 4] == 4'h0 && !bus.dp_in[i]) begin
                en_d[i] = 1'b0;
            end else begin
                supp = 1'b0;
            end
        end
    end
`else
    always_comb begin
        en_d = bus.digit_en;
    end
`endif

    always_ff @(posedge clock) begin
        if (Reset) begin
            presc_q   <= '0;
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            sh_en_q   <= '0;
            first_q   <= 1'b1;
            an_q      <= '1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            presc_q <= presc_q + DIVIDE_BY'(1);
            idx_q   <= idx_d;
            first_q <= 1'b0;
            // The first clock out of reset loads the shadow so frame 0 is valid.
            if (wrap || first_q) begin
                sh_data_q <= bus.data;
                sh_dp_q   <= bus.dp_in;
                sh_en_q   <= en_d;
            end
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            tick_q <= wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scanner_n.sv
// Directed bench for seven_seg_scanner_n at DIGITS=4, DIVIDE_BY=4, BRIGHT_W=2.
// Define SEVSEG_LZ_BLANK_EN to cover leading-zero blanking.
module tb_seven_seg_scanner_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n = 0;

    seven_seg_scanner_n_if #(.DIGITS(4), .BRIGHT_W(2)) sif ();

    seven_seg_scanner_n #(
        .DIGITS(4),
        .DIVIDE_BY(4),
        .BRIGHT_W(2)
    ) dut (
        .clock(clk),
        .Reset(rst),
        .bus(sif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic run_to(input int k);
        while (n < k) tick();
    endtask

    // After this, n counts edges since release; n=0 is the first low-Reset edge.
    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n = -1;
    endtask

    task automatic count_frame(input logic [3:0] target, output int lows,
                               output int hits, output int dpl,
                               output int ticks);
        lows = 0; hits = 0; dpl = 0; ticks = 0;
        repeat (64) begin
            tick();
            if (sif.an != 4'hF) lows++;
            if (sif.an == target) hits++;
            if (sif.dp == 1'b0) dpl++;
            if (sif.frame_tick) ticks++;
        end
    endtask

    logic [3:0] an_exp [4];
    logic [6:0] seg_exp [4];
    int lows, hits, dpl, ticks;

    initial begin
        an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_exp = '{7'h0E, 7'h08, 7'h24, 7'h79};
        @(negedge clk);
        sif.data       = 16'h12AF;
        sif.dp_in      = 4'h0;
        sif.digit_en   = 4'hF;
        sif.brightness = 2'd3;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_an", sif.an, 4'hF);
        chk("rst_seg", sif.seg, 7'h7F);
        chk("rst_dp", sif.dp, 1'b1);
        chk("rst_tick", sif.frame_tick, 1'b0);
        rst = 1'b0;
        n = -1;

        for (int k = 0; k < 4; k++) begin
            run_to(16 * k + 2);
            chk($sformatf("scan_an%0d", k), sif.an, an_exp[k]);
            chk($sformatf("scan_seg%0d", k), sif.seg, seg_exp[k]);
            chk($sformatf("scan_dp%0d", k), sif.dp, 1'b1);
        end
        run_to(62);
        chk("tick_62", sif.frame_tick, 1'b0);
        run_to(63);
        chk("tick_63", sif.frame_tick, 1'b1);
        run_to(64);
        chk("tick_64", sif.frame_tick, 1'b0);
        for (int k = 4; k < 8; k++) begin
            run_to(16 * k + 2);
            chk($sformatf("scan_an%0d", k), sif.an, an_exp[k % 4]);
            chk($sformatf("scan_seg%0d", k), sif.seg, seg_exp[k % 4]);
        end
        run_to(16 * 8 + 13);
        chk("pwm_off_b3", sif.an, 4'hF);

        do_reset();
        run_to(0);
        count_frame(4'hE, lows, hits, dpl, ticks);
        chk("b3_lows", lows, 48);
        chk("b3_ticks", ticks, 1);

        sif.brightness = 2'd1;
        do_reset();
        run_to(0);
        count_frame(4'hE, lows, hits, dpl, ticks);
        chk("b1_lows", lows, 16);
        chk("b1_dig0", hits, 4);

        sif.brightness = 2'd0;
        do_reset();
        run_to(0);
        count_frame(4'hE, lows, hits, dpl, ticks);
        chk("b0_lows", lows, 0);

        sif.brightness = 2'd3;
        sif.digit_en   = 4'h0;
        do_reset();
        run_to(0);
        count_frame(4'hE, lows, hits, dpl, ticks);
        chk("en0_lows", lows, 0);
        chk("en0_ticks", ticks, 1);

        sif.digit_en = 4'hF;
        sif.data     = 16'h1111;
        do_reset();
        run_to(20);
        sif.data = 16'h2222;
        run_to(34);
        chk("mid_an", sif.an, 4'hB);
        chk("mid_seg2", sif.seg, 7'h79);
        run_to(50);
        chk("mid_seg3", sif.seg, 7'h79);
        run_to(66);
        chk("next_an", sif.an, 4'hE);
        chk("next_seg", sif.seg, 7'h24);
        run_to(126);
        sif.data = 16'h3333;
        run_to(127);
        sif.data = 16'h4444;
        run_to(130);
        chk("wrap_same", sif.seg, 7'h30);
        run_to(194);
        chk("wrap_next", sif.seg, 7'h19);

        rst = 1'b1;
        tick();
        chk("mrst_an", sif.an, 4'hF);
        chk("mrst_seg", sif.seg, 7'h7F);
        chk("mrst_dp", sif.dp, 1'b1);
        rst = 1'b0;
        n = -1;
        run_to(2);
        chk("mrst_idx", sif.an, 4'hE);
        chk("mrst_val", sif.seg, 7'h19);

        sif.data     = 16'h12AF;
        sif.dp_in    = 4'b0100;
        sif.digit_en = 4'b1011;
        do_reset();
        run_to(0);
        count_frame(4'hB, lows, hits, dpl, ticks);
        chk("dp_blank_anB", hits, 0);
        chk("dp_blank_dp", dpl, 0);
        chk("dp_blank_lows", lows, 36);

        sif.digit_en = 4'hF;
        do_reset();
        run_to(0);
        count_frame(4'hB, lows, hits, dpl, ticks);
        chk("dp2_cnt", dpl, 12);
        chk("dp2_anB", hits, 12);
        run_to(82);
        chk("dp2_off", sif.dp, 1'b1);
        run_to(98);
        chk("dp2_on", sif.dp, 1'b0);

        sif.dp_in = 4'h0;
        sif.data  = 16'h0050;
`ifdef SEVSEG_LZ_BLANK_EN
        do_reset();
        run_to(2);
        chk("lz_d0_an", sif.an, 4'hE);
        chk("lz_d0_seg", sif.seg, 7'h40);
        run_to(18);
        chk("lz_d1_an", sif.an, 4'hD);
        chk("lz_d1_seg", sif.seg, 7'h12);
        do_reset();
        run_to(0);
        count_frame(4'hB, lows, hits, dpl, ticks);
        chk("lz_lows", lows, 24);
        chk("lz_d2", hits, 0);
        sif.data = 16'h0000;
        do_reset();
        run_to(0);
        count_frame(4'hE, lows, hits, dpl, ticks);
        chk("lz0_lows", lows, 12);
        chk("lz0_d0", hits, 12);
        run_to(66);
        chk("lz0_seg", sif.seg, 7'h40);
`else
        do_reset();
        run_to(18);
        chk("nlz_d1_seg", sif.seg, 7'h12);
        run_to(34);
        chk("nlz_d2_an", sif.an, 4'hB);
        chk("nlz_d2_seg", sif.seg, 7'h40);
        run_to(50);
        chk("nlz_d3_an", sif.an, 4'h7);
        chk("nlz_d3_seg", sif.seg, 7'h40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
